// File: rtl/varredura_quatro_displays.sv
`default_nettype none
// ============================================================================
// Module      : varredura_quatro_displays
// Description : Multiplexed driver for a four-digit common-anode 7-segment
//               display. Captures BCD digits plus sign on a strobe, commits
//               them at frame boundaries, scans with anti-ghosting blanking,
//               suppresses leading zeros, places a minus sign and flags
//               non-BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module varredura_quatro_displays #(
    parameter int CICLOS_POR_DIGITO = 50000,
    parameter bit APAGA_ZEROS       = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       atualiza,
    input  logic       negativo,
    input  logic [3:0] milhar,
    input  logic [3:0] centena,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    output logic [6:0] segmentos,
    output logic [3:0] anodo,
    output logic       sinal,
    output logic       invalido
);

    localparam int              c_PW     = $clog2(CICLOS_POR_DIGITO);
    localparam logic [c_PW-1:0] c_ULTIMO = c_PW'(CICLOS_POR_DIGITO - 1);
    localparam logic [6:0]      c_BRANCO = 7'b1111111;
    localparam logic [6:0]      c_MENOS  = 7'b0111111;

    // Scan position
    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_indice;

    // Pending (captured) and committed (displayed) values; index 3 = milhar
    logic [3:0][3:0] r_pend;
    logic            r_pend_neg;
    logic            r_pendente;
    logic [3:0][3:0] r_com;
    logic            r_com_neg;

    logic [6:0]      r_seg;
    logic            r_sinal;
    logic            r_invalido;

    logic [3:0][3:0] w_entrada;
    logic [3:0][3:0] w_nd;
    logic            w_nneg;
    logic            w_vira;
    logic            w_fim;
    logic [1:0]      w_idx_prox;
    logic [3:0]      w_lead;
    logic [3:0]      w_pos_menos;
    logic            w_nao_zero;
    logic            w_mostra_menos;
    logic            w_sinal_prox;
    logic            w_inval_prox;
    logic [6:0]      w_seg_prox;
    logic [3:0]      w_anodo;

    assign w_entrada  = {milhar, centena, dezena, unidade};
    assign w_vira     = (r_presc == c_ULTIMO);
    assign w_fim      = w_vira && (r_indice == 2'd0);
    assign w_idx_prox = r_indice - 2'd1;

    // Value that will be committed after this edge (unchanged outside frame end)
    always_comb begin
        w_nd   = r_com;
        w_nneg = r_com_neg;
        if (w_fim) begin
            if (atualiza) begin
                w_nd   = w_entrada;
                w_nneg = negativo;
            end else if (r_pendente) begin
                w_nd   = r_pend;
                w_nneg = r_pend_neg;
            end
        end
    end

    // A position is lead when it and every more significant digit are zero;
    // non-BCD digits are nonzero so they count as significant
    assign w_lead[3] = (w_nd[3] == 4'd0);
    assign w_lead[2] = w_lead[3] && (w_nd[2] == 4'd0);
    assign w_lead[1] = w_lead[2] && (w_nd[1] == 4'd0);
    assign w_lead[0] = 1'b0;

    // The minus goes on the last lead position (just left of the first significant digit)
    assign w_pos_menos[3] = w_lead[3] && !w_lead[2];
    assign w_pos_menos[2] = w_lead[2] && !w_lead[1];
    assign w_pos_menos[1] = w_lead[1];
    assign w_pos_menos[0] = 1'b0;

    assign w_nao_zero     = |w_nd;
    assign w_mostra_menos = APAGA_ZEROS && w_nneg && w_nao_zero;
    assign w_sinal_prox   = w_nneg && w_nao_zero && (!APAGA_ZEROS || !w_lead[3]);
    assign w_inval_prox   = (w_nd[3] > 4'd9) || (w_nd[2] > 4'd9) ||
                            (w_nd[1] > 4'd9) || (w_nd[0] > 4'd9);

    function automatic logic [6:0] f_codifica(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0000110;
        endcase
        return s;
    endfunction

    // Pattern for the digit position that becomes active after the next wrap
    always_comb begin
        w_seg_prox = f_codifica(w_nd[w_idx_prox]);
        if (APAGA_ZEROS && w_lead[w_idx_prox]) begin
            w_seg_prox = (w_mostra_menos && w_pos_menos[w_idx_prox]) ? c_MENOS : c_BRANCO;
        end
    end

    // Anodes stay off during the first prescaler cycle of each digit slot
    always_comb begin
        w_anodo = 4'b1111;
        if (r_presc != '0) begin
            w_anodo[r_indice] = 1'b0;
        end
    end

    // Prescaler and digit index: milhar first, stepping down to unidade
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_indice <= 2'd3;
        end else if (w_vira) begin
            r_presc  <= '0;
            r_indice <= w_idx_prox;
        end else begin
            r_presc  <= r_presc + c_PW'(1);
        end
    end

    // Capture into pending; commit at end of frame (a coincident strobe goes straight through)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend     <= '0;
            r_pend_neg <= 1'b0;
            r_pendente <= 1'b0;
            r_com      <= '0;
            r_com_neg  <= 1'b0;
            r_sinal    <= 1'b0;
            r_invalido <= 1'b0;
        end else if (w_fim) begin
            r_com      <= w_nd;
            r_com_neg  <= w_nneg;
            r_pendente <= 1'b0;
            r_sinal    <= w_sinal_prox;
            r_invalido <= w_inval_prox;
        end else if (atualiza) begin
            r_pend     <= w_entrada;
            r_pend_neg <= negativo;
            r_pendente <= 1'b1;
        end
    end

    // Segment register loads the new position's pattern as the slot begins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seg <= c_BRANCO;
        end else if (w_vira) begin
            r_seg <= w_seg_prox;
        end
    end

    assign segmentos = r_seg;
    assign anodo     = w_anodo;
    assign sinal     = r_sinal;
    assign invalido  = r_invalido;

endmodule
`default_nettype wire

// File: doc/varredura_quatro_displays.md
Name: varredura_quatro_displays

Overview:
- Multiplexed driver for a four-digit common-anode 7-segment display.
- Sits directly downstream of the binary-to-BCD converter. Consumes its milhar/centena/dezena/unidade digits plus a sign bit taken from numero[15].
- Latches new values only at frame boundaries, so a scan never shows a mix of old and new digits.
- Scans the digits with anti-ghosting blanking, suppresses leading zeros, places a minus sign, and flags non-BCD input.

Parameters:
- CICLOS_POR_DIGITO, 50000, clock cycles each digit position is held. Legal range 2 or more.
- APAGA_ZEROS, 1, 1 = blank leading zeros and float the minus sign; 0 = show all four digits, sign on `sinal` only.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- atualiza  input  1  single-cycle strobe; capture the digit inputs and `negativo`.
- negativo  input  1  sign of the value, 1 = negative.
- milhar  input  4  BCD thousands digit.
- centena  input  4  BCD hundreds digit.
- dezena  input  4  BCD tens digit.
- unidade  input  4  BCD units digit.
- segmentos  output  7  active-low segments, bit6..bit0 = g,f,e,d,c,b,a.
- anodo  output  4  active-low one-hot digit enable, bit3 = milhar … bit0 = unidade.
- sinal  output  1  minus LED, high when a negative sign cannot be placed on a digit.
- invalido  output  1  high while any committed digit is greater than 9.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - Prescaler = 0, digit index = 3.
  - Pending and committed registers cleared, pendente flag = 0.
  - Outputs: segmentos = 7'b1111111, anodo = 4'b1111, sinal = 0, invalido = 0.
- Capture:
  - On a clock edge with atualiza = 1, the inputs are copied into the pending registers and pendente is set.
  - A later atualiza before commit overwrites the pending registers; the last one wins.
- Commit:
  - Happens on the edge where the prescaler is at CICLOS_POR_DIGITO-1 and the index is 0, i.e. at the end of the frame.
  - If pendente = 1, pending is copied to committed and pendente is cleared.
  - If atualiza is asserted on that same edge, the new inputs go directly to committed and pendente stays 0.
- Scan sequence:
  - Prescaler counts 0..CICLOS_POR_DIGITO-1 and then wraps.
  - On wrap, the index steps 3→2→1→0→3.
  - One frame = 4 × CICLOS_POR_DIGITO cycles.
- Anti-ghosting:
  - While prescaler = 0, anodo = 4'b1111.
  - While prescaler = 1..N-1, anodo has only bit[index] low.
  - segmentos is registered and loaded on the edge entering prescaler = 0 with the pattern for the new index.
- Blanking:
  - With APAGA_ZEROS = 1, a position is "lead" when its digit and all more significant digits equal 0.
  - unidade is never lead.
  - A digit greater than 9 counts as significant.
- Minus sign (when negativo = 1 and the committed value is nonzero):
  - The lead position immediately left of the first significant digit shows minus, 7'b0111111.
  - If no lead position exists (milhar significant) or APAGA_ZEROS = 0, sinal = 1 instead.
  - A committed value of zero with negativo = 1 shows no sign and sinal = 0.
- Segment encoding (gfedcba, active-low):

  | Pattern | Bits |
  |---|---|
  | 0 | 1000000 |
  | 1 | 1111001 |
  | 2 | 0100100 |
  | 3 | 0110000 |
  | 4 | 0011001 |
  | 5 | 0010010 |
  | 6 | 0000010 |
  | 7 | 1111000 |
  | 8 | 0000000 |
  | 9 | 0010000 |
  | digit 10..15 | E = 0000110 |
  | blank | 1111111 |

- sinal and invalido are registered and update on the commit edge.
- Reset asserted mid-frame aborts the scan immediately. A pending capture is discarded.
- After reset release the scan restarts at milhar with prescaler 0, and displays value 0: three blanks (APAGA_ZEROS = 1), unidade = 1000000.

Test Plan (CICLOS_POR_DIGITO = 4, frame = 16 cycles):
- Reset mid-frame, then release → anodo = 1111 and segmentos = 1111111 while reset is low. Next frame: anodo 0111/1011/1101 with blanks, then 1110 with 1000000. sinal = 0, invalido = 0.
- Pulse atualiza with 1,2,3,4 (positive) at cycle 6 of a frame → current frame still shows 0. Next frame shows 1111001, 0100100, 0110000, 0011001. anodo = 1111 on every prescaler-0 cycle.
- Commit 0,0,4,2 negative → milhar blank, centena 0111111, dezena 0011001, unidade 0100100, sinal = 0.
- Commit 1,2,3,4 negative → all four digits shown, sinal = 1 from the commit edge.
- Commit 0,12,0,5 → centena shows 0000110, dezena shows 1000000 (not lead), invalido = 1. Then commit 0,0,0,0 with negativo = 1 → no minus, sinal = 0, invalido = 0.
- Two atualiza pulses in one frame (3,3,3,3 then 0,0,0,7) with APAGA_ZEROS = 0 → only 0007 appears, as 1000000, 1000000, 1000000, 1111000. Strobe coinciding with the commit edge is shown in the immediately following frame.
